seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter SIZE, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port A  input  SIZE  multiplicand; captured on the accepting edge.
REQ-006 SHALL have port B  input  SIZE  multiplier; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while a multiplication is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; P valid.
REQ-009 SHALL have port P  output  2*SIZE  product.

Function
REQ-010 SHALL implement the states IDLE, RUN, FIX (present only with SIGNED_MUL_EN) and DONE.
REQ-011 SHALL accept start on a rising edge while in IDLE or DONE, loading M=A, Q=B, ACC=0 and iteration count=0, and entering RUN.
REQ-012 SHALL, in each RUN cycle, form ACC+M through one SIZE-bit instance of the team adder with Cin=0 when Q[0]=1, otherwise ACC+0, then shift {Cout, sum, Q} right by one bit into {ACC, Q}.
REQ-013 SHALL leave RUN after exactly SIZE iterations, entering DONE, or FIX when SIGNED_MUL_EN is defined.
REQ-014 SHALL produce P={ACC, Q} equal to the full unsigned 2*SIZE-bit product A*B, with no truncation.
REQ-015 SHALL assert done exactly SIZE clock edges after the accepting edge in unsigned mode, and SIZE+1 edges when SIGNED_MUL_EN is defined; done lasts one cycle.
REQ-016 SHALL drive busy=1 in RUN and FIX, and busy=0 in IDLE and DONE.
REQ-017 SHALL ignore start while busy=1; the operation in progress and its operands are unaffected.
REQ-018 SHALL accept a start asserted in the DONE cycle (back-to-back operation), giving zero idle cycles between operations.
REQ-019 SHALL hold P stable from the done cycle until the edge accepting the next start.
REQ-020 SHALL move from DONE to IDLE when start=0.
REQ-021 SHALL sample A and B only on the accepting edge; changes during RUN have no effect.

Reset
REQ-022 SHALL, on rst_n=0, immediately and asynchronously force state=IDLE, busy=0, done=0, P=0, and clear all internal registers, including mid-operation.
REQ-023 SHALL discard any aborted operation, never asserting done for it, and accept a new start on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro SEQ_MULTIPLIER_SIGNED_MUL_EN defined, add port is_signed (input, 1), sampled with A and B: when is_signed=1, A and B are two's complement.
REQ-025 SHALL, with the macro and is_signed=1, load |A| and |B| on the accepting edge, then in FIX negate {ACC,Q} when the sign bits of A and B differ; SIZE+1 cycles total, independent of is_signed.
REQ-026 SHALL, without the macro, omit is_signed and the FIX state, give unsigned-only behaviour, and have a latency of SIZE.

Verification
REQ-027 Bench SHALL cover: SIZE=32, A=3, B=5, start for one cycle -> done 32 edges later, P=0x000000000000000F, busy low in the done cycle.
REQ-028 Bench SHALL cover: A=B=0xFFFFFFFF -> P=0xFFFFFFFE00000001 (carry-out of the top iteration retained).
REQ-029 Bench SHALL cover: start, then at cycle 10 start again with A=7 -> ignored; the first result is unchanged, and done is pulsed once.
REQ-030 Bench SHALL cover: rst_n pulsed low at cycle 15 of an operation -> P=0, busy=0 immediately, no done; a new start of 2*2 -> P=4.
REQ-031 Bench SHALL cover: start held high across the done cycle with new A=6, B=7 -> second operation accepted in the done cycle, P=42 exactly 32 edges later.
REQ-032 Bench SHALL cover, with the macro: is_signed=1, A=0xFFFFFFFD (-3), B=5 -> done after 33 edges, P=0xFFFFFFFFFFFFFFF1; is_signed=0, same operands -> P=0x00000004FFFFFFF1.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one SIZE-bit add per cycle, full 2*SIZE-bit product.
// Latency: done SIZE edges after accepting start (SIZE+1 with SEQ_MULTIPLIER_SIGNED_MUL_EN).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.

module seq_multiplier_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(i_cin);
endmodule

module seq_multiplier #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   A,
    input  logic [SIZE-1:0]   B,
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
    input  logic              is_signed,
`endif
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] P
);
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
        S_FIX,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_busy;
    logic              w_done;
    logic              w_last;

    logic [SIZE-1:0]   r_m;
    logic [SIZE-1:0]   r_q;
    logic [SIZE-1:0]   r_acc;
    logic [CW-1:0]     r_cnt;

    logic [SIZE-1:0]   w_addend;
    logic [SIZE-1:0]   w_sum;
    logic              w_cout;
    logic [SIZE-1:0]   w_a_load;
    logic [SIZE-1:0]   w_b_load;

    assign w_last   = (r_cnt == CW'(SIZE - 1));
    assign w_addend = r_q[0] ? r_m : '0;

    seq_multiplier_adder #(.W(SIZE)) u_adder (
        .i_a    (r_acc),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
    logic              r_neg;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [2*SIZE-1:0] w_prod_neg;

    // Magnitudes are loaded so the core stays unsigned; the sign is restored in FIX.
    assign w_a_neg    = is_signed && A[SIZE-1];
    assign w_b_neg    = is_signed && B[SIZE-1];
    assign w_a_load   = w_a_neg ? (~A + SIZE'(1)) : A;
    assign w_b_load   = w_b_neg ? (~B + SIZE'(1)) : B;
    assign w_prod_neg = ~{r_acc, r_q} + (2*SIZE)'(1);
`else
    assign w_a_load   = A;
    assign w_b_load   = B;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
            S_FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
            r_neg <= 1'b0;
`endif
        end else if (w_accept) begin
            r_m   <= w_a_load;
            r_q   <= w_b_load;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
            r_neg <= w_a_neg ^ w_b_neg;
`endif
        end else if (r_state == S_RUN) begin
            // Carry-out becomes the new ACC MSB so the top partial product is never lost.
            r_acc <= {w_cout, w_sum[SIZE-1:1]};
            r_q   <= {w_sum[0], r_q[SIZE-1:1]};
            r_cnt <= r_cnt + CW'(1);
        end
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
        else if (r_state == S_FIX && r_neg) begin
            {r_acc, r_q} <= w_prod_neg;
        end
`endif
    end

    assign busy = w_busy;
    assign done = w_done;
    assign P    = {r_acc, r_q};

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus ignore/reset/back-to-back sequences.
module tb_seq_multiplier;
    localparam int SIZE = 32;
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
    localparam int LAT = SIZE + 1;
`else
    localparam int LAT = SIZE;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [SIZE-1:0]   A;
    logic [SIZE-1:0]   B;
    logic              is_signed;
    logic              busy;
    logic              done;
    logic [2*SIZE-1:0] P;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic              sgn;
        logic [2*SIZE-1:0] p;
    } vec_t;
    vec_t vecs[$];

    seq_multiplier #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .P         (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [2*SIZE-1:0] act, input logic [2*SIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s, input logic [2*SIZE-1:0] p);
        vec_t v;
        v.a = a; v.b = b; v.sgn = s; v.p = p;
        vecs.push_back(v);
    endtask

    // Counts edges after the accept edge until done is seen; returns at a negedge.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done && n < 200);
    endtask

    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s, output int n);
        start = 1'b1; A = a; B = b; is_signed = s;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
    endtask

    initial begin
        int n;
        int n2;
        int cnt;
        int first_c;
        logic [2*SIZE-1:0] p_at_done;
        logic [2*SIZE-1:0] p_hold;

        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
        add_vec(32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F);
        add_vec(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001);
        add_vec(32'd0,          32'hDEAD_BEEF,  1'b0, 64'h0);
        add_vec(32'hFFFF_FFFF,  32'd1,          1'b0, 64'h0000_0000_FFFF_FFFF);
        add_vec(32'h0001_0000,  32'h0001_0000,  1'b0, 64'h0000_0001_0000_0000);
        add_vec(32'h8000_0000,  32'h8000_0000,  1'b0, 64'h4000_0000_0000_0000);
        add_vec(32'hFFFF_FFFF,  32'd2,          1'b0, 64'h0000_0001_FFFF_FFFE);
`ifdef SEQ_MULTIPLIER_SIGNED_MUL_EN
        add_vec(32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        add_vec(32'hFFFF_FFFD,  32'd5,          1'b0, 64'h0000_0004_FFFF_FFF1);
        add_vec(32'hFFFF_FFFD,  32'hFFFF_FFFB,  1'b1, 64'h0000_0000_0000_000F);
        add_vec(32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000);
`endif

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_p",    P,         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, n);
            check($sformatf("vec%0d_latency", i), 64'(n), 64'(LAT));
            check($sformatf("vec%0d_p", i), P, vecs[i].p);
            check($sformatf("vec%0d_busy_in_done", i), 64'(busy), 64'd0);
            p_hold = P;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_p_hold", i), P, p_hold);
            @(negedge clk);
        end

        // Start during an operation must be ignored.
        start = 1'b1; A = 32'd9; B = 32'd11; is_signed = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0; first_c = 0; p_at_done = '0;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                cnt++;
                if (first_c == 0) begin
                    first_c = c;
                    p_at_done = P;
                end
            end
            if (c == 9) begin
                start = 1'b1; A = 32'd7;
            end else if (c == 10) begin
                start = 1'b0;
            end
        end
        check("ignore_done_count", 64'(cnt), 64'd1);
        check("ignore_latency", 64'(first_c), 64'(LAT));
        check("ignore_p", p_at_done, 64'd99);
        check("ignore_p_hold", P, 64'd99);

        // Asynchronous reset mid-operation.
        start = 1'b1; A = 32'd100; B = 32'd100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_p", P, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort_no_done", 64'(cnt), 64'd0);
        run_op(32'd2, 32'd2, 1'b0, n);
        check("after_reset_latency", 64'(n), 64'(LAT));
        check("after_reset_p", P, 64'd4);
        @(negedge clk);

        // Back-to-back: start held across the done cycle.
        start = 1'b1; A = 32'd4; B = 32'd5; is_signed = 1'b0;
        @(posedge clk);
        #1 A = 32'd6; B = 32'd7;
        wait_done(n);
        check("b2b_first_latency", 64'(n), 64'(LAT));
        check("b2b_first_p", P, 64'd20);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy_after_accept", 64'(busy), 64'd1);
        check("b2b_done_dropped", 64'(done), 64'd0);
        wait_done(n2);
        check("b2b_second_latency", 64'(n2), 64'(LAT));
        check("b2b_second_p", P, 64'd42);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
